// File: rtl/address_sequencer.sv
// Address sequencer: walks [ADDR_BASE, ADDR_BASE+ADDR_COUNT) with offset/stride/length.
// Optional repeat mode enabled by defining ADDRESS_SEQUENCER_REPEAT_EN.
module address_sequencer #(
    parameter int ADDR_WIDTH   = 4,
    parameter int ADDR_BASE    = 0,
    parameter int ADDR_COUNT   = 16,
    parameter int STRIDE_WIDTH = 4,
    parameter int LENGTH_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [ADDR_WIDTH-1:0]   start_offset,
    input  logic [STRIDE_WIDTH-1:0] start_stride,
    input  logic [LENGTH_WIDTH-1:0] start_length,
    input  logic                    start_repeat,
    input  logic                    abort,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic [ADDR_WIDTH-1:0]   raw_address,
    output logic                    addr_last,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned           COUNT  = ADDR_COUNT;
    localparam logic [ADDR_WIDTH:0]   CNT_W  = (ADDR_WIDTH+1)'(ADDR_COUNT);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);
    localparam logic [LENGTH_WIDTH-1:0] LEN_TWO = LENGTH_WIDTH'(2);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH:0]     sum;
    logic [ADDR_WIDTH-1:0]   next_index;
    logic                    bad_cmd;
    logic                    reload;
    logic [ADDR_WIDTH-1:0]   reload_index;
    logic [LENGTH_WIDTH-1:0] reload_len;

    assign start_ready = (state == IDLE);
    assign bad_cmd = (32'(start_offset) >= COUNT) ||
                     (32'(start_stride) >= COUNT);

`ifdef ADDRESS_SEQUENCER_REPEAT_EN
    logic                    repeat_q;
    logic [ADDR_WIDTH-1:0]   offset_q;
    logic [LENGTH_WIDTH-1:0] length_q;

    // Remember the command so each pass can restart from its offset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            repeat_q <= 1'b0;
            offset_q <= '0;
            length_q <= '0;
        end else if (state == IDLE && start_valid && !bad_cmd &&
                     start_length != '0) begin
            repeat_q <= start_repeat;
            offset_q <= start_offset;
            length_q <= start_length;
        end
    end

    assign reload       = repeat_q;
    assign reload_index = offset_q;
    assign reload_len   = length_q;
`else
    logic unused_repeat;

    assign unused_repeat = start_repeat;
    assign reload        = 1'b0;
    assign reload_index  = '0;
    assign reload_len    = '0;
`endif

    // Next index with a single conditional wrap; stride < ADDR_COUNT.
    always_comb begin
        sum        = {1'b0, index_q} + {1'b0, stride_q};
        next_index = sum[ADDR_WIDTH-1:0];
        if (sum >= CNT_W) begin
            next_index = ADDR_WIDTH'(sum - CNT_W);
        end
    end

    // Control FSM with registered address outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            index_q     <= '0;
            stride_q    <= '0;
            remaining   <= '0;
            raw_address <= BASE;
            addr_valid  <= 1'b0;
            addr_last   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        if (bad_cmd) begin
                            error <= 1'b1;
                        end else if (start_length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            index_q     <= start_offset;
                            stride_q    <= ADDR_WIDTH'(start_stride);
                            remaining   <= start_length;
                            raw_address <= BASE + start_offset;
                            addr_valid  <= 1'b1;
                            addr_last   <= (start_length == LEN_ONE);
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (addr_valid && addr_ready) begin
                        if (remaining == LEN_ONE) begin
                            if (reload) begin
                                index_q     <= reload_index;
                                remaining   <= reload_len;
                                raw_address <= BASE + reload_index;
                                addr_last   <= (reload_len == LEN_ONE);
                            end else begin
                                remaining  <= '0;
                                addr_valid <= 1'b0;
                                addr_last  <= 1'b0;
                                done       <= 1'b1;
                                state      <= DONE;
                            end
                        end else begin
                            index_q     <= next_index;
                            raw_address <= BASE + next_index;
                            remaining   <= remaining - LEN_ONE;
                            addr_last   <= (remaining == LEN_TWO);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer (BASE=5, COUNT=6).
// Repeat-mode vectors run when ADDRESS_SEQUENCER_REPEAT_EN is defined.
module tb_address_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] start_offset;
    logic [3:0] start_stride;
    logic [7:0] start_length;
    logic       start_repeat;
    logic       abort;
    logic       addr_valid;
    logic       addr_ready;
    logic [3:0] raw_address;
    logic       addr_last;
    logic       done;
    logic       error;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[8];

    address_sequencer #(
        .ADDR_WIDTH  (4),
        .ADDR_BASE   (5),
        .ADDR_COUNT  (6),
        .STRIDE_WIDTH(4),
        .LENGTH_WIDTH(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_offset(start_offset),
        .start_stride(start_stride),
        .start_length(start_length),
        .start_repeat(start_repeat),
        .abort       (abort),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .raw_address (raw_address),
        .addr_last   (addr_last),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmd(input int off, input int str, input int len, input bit rep);
        check("start_ready", int'(start_ready), 1);
        start_valid  = 1'b1;
        start_offset = off[3:0];
        start_stride = str[3:0];
        start_length = len[7:0];
        start_repeat = rep;
        @(negedge clock);
        start_valid  = 1'b0;
        start_repeat = 1'b0;
    endtask

    task automatic run_seq(input int n, input bit bp);
        int k = 0;
        int cyc = 0;
        int pat[4] = '{1, 0, 0, 1};
        while (k < n && cyc < 64) begin
            check("valid", int'(addr_valid), 1);
            check("raw", int'(raw_address), exp_q[k]);
            check("last", int'(addr_last), (k == n - 1) ? 1 : 0);
            check("no_done", int'(done), 0);
            if (bp) addr_ready = (pat[cyc % 4] != 0);
            @(negedge clock);
            if (addr_ready) k++;
            cyc++;
        end
        if (k < n) check("seq_timeout", k, n);
        addr_ready = 1'b1;
        check("end_valid", int'(addr_valid), 0);
        check("done_pulse", int'(done), 1);
        check("ready_in_done", int'(start_ready), 0);
        @(negedge clock);
        check("done_clear", int'(done), 0);
        check("ready_idle", int'(start_ready), 1);
    endtask

    task automatic reject(input int off, input int str);
        cmd(off, str, 3, 1'b0);
        check("err_pulse", int'(error), 1);
        check("err_valid", int'(addr_valid), 0);
        check("err_idle", int'(start_ready), 1);
        @(negedge clock);
        check("err_clear", int'(error), 0);
        check("err_no_done", int'(done), 0);
    endtask

    initial begin
        reset        = 1'b1;
        start_valid  = 1'b0;
        start_offset = '0;
        start_stride = '0;
        start_length = '0;
        start_repeat = 1'b0;
        abort        = 1'b0;
        addr_ready   = 1'b1;
        #1;
        check("rst_valid", int'(addr_valid), 0);
        check("rst_raw", int'(raw_address), 5);
        check("rst_last", int'(addr_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        exp_q = '{5, 6, 7, 8, 9, 10, 5, 0};
        cmd(0, 1, 7, 1'b0);
        run_seq(7, 1'b0);

        exp_q = '{9, 6, 9, 6, 0, 0, 0, 0};
        cmd(4, 3, 4, 1'b0);
        run_seq(4, 1'b0);

        exp_q = '{10, 9, 8, 0, 0, 0, 0, 0};
        cmd(5, 5, 3, 1'b0);
        run_seq(3, 1'b0);

        exp_q = '{5, 6, 7, 8, 9, 10, 5, 0};
        cmd(0, 1, 7, 1'b0);
        run_seq(7, 1'b1);

        exp_q = '{9, 6, 9, 6, 0, 0, 0, 0};
        cmd(4, 3, 4, 1'b0);
        run_seq(4, 1'b1);

        cmd(0, 1, 0, 1'b0);
        check("zl_valid", int'(addr_valid), 0);
        check("zl_done", int'(done), 1);
        check("zl_ready_lo", int'(start_ready), 0);
        @(negedge clock);
        check("zl_ready_hi", int'(start_ready), 1);
        check("zl_done_clr", int'(done), 0);

        reject(0, 6);
        reject(6, 1);

        cmd(0, 1, 5, 1'b0);
        check("ab_raw0", int'(raw_address), 5);
        @(negedge clock);
        check("ab_raw1", int'(raw_address), 6);
        @(negedge clock);
        check("ab_raw2", int'(raw_address), 7);
        check("ab_valid2", int'(addr_valid), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("ab_valid", int'(addr_valid), 0);
        check("ab_done", int'(done), 1);
        @(negedge clock);
        check("ab_done_clr", int'(done), 0);
        check("ab_idle", int'(start_ready), 1);

        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("ab_idle_ign", int'(done), 0);

        cmd(0, 1, 5, 1'b0);
        @(negedge clock);
        check("rs_raw1", int'(raw_address), 6);
        #2;
        reset = 1'b1;
        #1;
        check("rs_valid", int'(addr_valid), 0);
        check("rs_raw", int'(raw_address), 5);
        check("rs_last", int'(addr_last), 0);
        check("rs_done", int'(done), 0);
        check("rs_idle", int'(start_ready), 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rs_no_done", int'(done), 0);
        check("rs_still_idle", int'(addr_valid), 0);

`ifdef ADDRESS_SEQUENCER_REPEAT_EN
        exp_q = '{6, 8, 10, 0, 0, 0, 0, 0};
        cmd(1, 2, 3, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check("rp_valid", int'(addr_valid), 1);
            check("rp_raw", int'(raw_address), exp_q[i % 3]);
            check("rp_last", int'(addr_last), (i % 3 == 2) ? 1 : 0);
            check("rp_no_done", int'(done), 0);
            @(negedge clock);
        end
        check("rp_raw_again", int'(raw_address), 6);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("rp_end_valid", int'(addr_valid), 0);
        check("rp_done", int'(done), 1);
        @(negedge clock);
        check("rp_done_once", int'(done), 0);
        check("rp_idle", int'(start_ready), 1);
`else
        exp_q = '{9, 6, 9, 6, 0, 0, 0, 0};
        cmd(4, 3, 4, 1'b1);
        run_seq(4, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Generates a stream of raw addresses that walks a fixed, non-power-of-2 address range [ADDR_BASE, ADDR_BASE+ADDR_COUNT) with programmable start offset, stride and length.
- Wraps modulo ADDR_COUNT.
- Sits directly upstream of the address range translator; its raw_address output feeds the translator's raw address input.
- Output uses a valid/ready handshake so downstream RAM-access stages can stall it.

Parameters:
ADDR_WIDTH, 4, width of raw_address; ADDR_BASE+ADDR_COUNT <= 2**ADDR_WIDTH is required.
ADDR_BASE, 0, first address of the range.
ADDR_COUNT, 16, number of addresses in the range, >= 1.
STRIDE_WIDTH, 4, width of start_stride.
LENGTH_WIDTH, 8, width of start_length.

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
start_valid  input  1  command request.
start_ready  output  1  high only in IDLE.
start_offset  input  ADDR_WIDTH  starting index into the range, relative to ADDR_BASE.
start_stride  input  STRIDE_WIDTH  index increment per address.
start_length  input  LENGTH_WIDTH  number of addresses to emit.
start_repeat  input  1  repeat mode request; used only with the optional feature.
abort  input  1  terminate the current sequence.
addr_valid  output  1  raw_address is valid.
addr_ready  input  1  downstream accepts the address.
raw_address  output  ADDR_WIDTH  ADDR_BASE + current index.
addr_last  output  1  marks the final address of a sequence.
done  output  1  one-cycle pulse at sequence end.
error  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - addr_valid, addr_last, done, error = 0.
  - raw_address = ADDR_BASE[ADDR_WIDTH-1:0].
  - Internal index, stride, remaining count = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - Command accepted when start_valid is high.
  - Reject if start_offset >= ADDR_COUNT or start_stride >= ADDR_COUNT. On reject: error pulses next cycle, state stays IDLE, nothing is captured.
  - start_length == 0: accepted, no address is emitted, go to DONE.
  - Otherwise: capture offset as index, stride, and length as remaining; go to RUN.
  - The first address is registered and visible with addr_valid = 1 on the cycle after acceptance (latency 1).
- RUN:
  - addr_valid = 1.
  - raw_address = ADDR_BASE + index, computed as registered output (no combinational path from inputs).
  - addr_last = (remaining == 1).
  - On addr_valid && addr_ready:
    - remaining decrements.
    - Next index = index + stride; if the sum >= ADDR_COUNT, subtract ADDR_COUNT (single subtraction is sufficient because stride < ADDR_COUNT).
    - Sum is computed in ADDR_WIDTH+1 bits; no overflow.
  - While addr_ready = 0: raw_address, addr_last and addr_valid hold stable. No address is ever dropped or duplicated.
  - When the last address is accepted: addr_valid = 0 next cycle, go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - start_ready = 0 in DONE.
- abort:
  - In RUN, takes priority over the handshake: addr_valid drops next cycle, the in-flight address is discarded, go to DONE (done still pulses).
  - Ignored in IDLE and DONE.
- Back-to-back: a new command is accepted no earlier than the IDLE cycle that follows DONE.
- Reset mid-RUN returns immediately to IDLE with all outputs at reset values. No done pulse.
- ADDR_COUNT == 1: every index is 0; any stride other than 0 is rejected.

Optional Feature:
- Macro: ADDRESS_SEQUENCER_REPEAT_EN.
- Defined:
  - start_repeat is captured with the command.
  - If set, acceptance of addr_last reloads the captured offset and length, emits the sequence again with no bubble cycle, and stays in RUN. No done pulse per pass.
  - The sequence ends only on abort, which goes to DONE and pulses done.
- Undefined: start_repeat is ignored (port kept; tie-off is legal) and every sequence ends after a single pass.

Test Plan:
All scenarios use ADDR_WIDTH=4, ADDR_BASE=5, ADDR_COUNT=6.
- Basic sequence: offset=0, stride=1, length=7, addr_ready=1 -> raw_address 5,6,7,8,9,10,5 on consecutive cycles starting 1 cycle after acceptance; addr_last only on the second 5; done pulses the cycle after.
- Stride wrap: offset=4, stride=3, length=4 -> 9,6,9,6.
- Back-pressure: same command with addr_ready toggled 1,0,0,1,... -> raw_address held stable while stalled; exact sequence preserved.
- Zero-length and bad commands:
  - length=0 -> no addr_valid; done pulses; start_ready returns high 2 cycles after acceptance.
  - stride=6 -> error pulse; stays IDLE.
  - offset=6 -> error pulse; stays IDLE.
- Abort and reset: abort asserted on the 3rd address of offset=0, stride=1, length=5 -> addr_valid low next cycle, done pulses. Reset asserted mid-RUN -> outputs 0 and raw_address = 5 immediately, no done.
- Repeat mode (macro defined): offset=1, stride=2, length=3, repeat=1 -> 6,8,10,6,8,10,... continuous until abort, then done pulses once.
